// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha round sequencer.
package chacha_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        OUT
    } state_t;

    localparam int unsigned CHACHA20_DOUBLE_ROUNDS = 10;

    localparam logic QR_COLUMN = 1'b0;
    localparam logic QR_DIAG   = 1'b1;

endpackage

// File: rtl/chacha_round_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
module chacha_round_counter #(
    parameter int unsigned MAX_COUNT = 19,
    parameter int unsigned W         = 5
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(MAX_COUNT));

    always_ff @(posedge clock) begin
        if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/chacha_round_ctrl.sv
// ChaCha quarter-round sequencer: load, 2N half-rounds, final add, output handshake.
// Optional block counter enabled by defining CHACHA_ROUND_CTRL_BLOCK_CTR_EN.
module chacha_round_ctrl
    import chacha_pkg::*;
#(
    parameter int unsigned NUM_DOUBLE_ROUNDS = CHACHA20_DOUBLE_ROUNDS,
    parameter int unsigned RND_W             = $clog2(2 * NUM_DOUBLE_ROUNDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             out_ready_i,
    output logic             ready_o,
    output logic             load_o,
    output logic             qr_en_o,
    output logic             diag_sel_o,
    output logic [RND_W-1:0] round_idx_o,
    output logic             add_o,
    output logic             out_valid_o
`ifdef CHACHA_ROUND_CTRL_BLOCK_CTR_EN
    ,
    output logic [31:0]      block_ctr_o,
    output logic             ctr_wrap_o
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [RND_W-1:0]   rnd_cnt;
    logic               rnd_tc;
    logic               rnd_clr;
    logic               rnd_en;

    // Counter is held at zero outside ROUND so round_idx_o starts at 0 on entry.
    assign rnd_clr = reset || abort_i || (state != ROUND);
    assign rnd_en  = (state == ROUND);

    chacha_round_counter #(
        .MAX_COUNT (2 * NUM_DOUBLE_ROUNDS - 1),
        .W         (RND_W)
    ) u_round_counter (
        .clock (clock),
        .clr   (rnd_clr),
        .en    (rnd_en),
        .count (rnd_cnt),
        .tc    (rnd_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else if (abort_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ready_o     = 1'b0;
        load_o      = 1'b0;
        qr_en_o     = 1'b0;
        diag_sel_o  = QR_COLUMN;
        round_idx_o = '0;
        add_o       = 1'b0;
        out_valid_o = 1'b0;

        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                load_o    = 1'b1;
                state_nxt = ROUND;
            end
            ROUND: begin
                qr_en_o     = 1'b1;
                round_idx_o = rnd_cnt;
                diag_sel_o  = rnd_cnt[0];
                if (rnd_tc) begin
                    state_nxt = FINAL;
                end
            end
            FINAL: begin
                add_o     = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef CHACHA_ROUND_CTRL_BLOCK_CTR_EN
    logic [31:0] block_ctr_q;
    logic        ctr_wrap_q;
    logic        handshake;

    assign handshake = (state == OUT) && out_ready_i;

    // Abort outranks the handshake, so an aborted OUT never counts a block.
    always_ff @(posedge clock) begin
        if (reset) begin
            block_ctr_q <= '0;
            ctr_wrap_q  <= 1'b0;
        end else if (abort_i) begin
            ctr_wrap_q  <= 1'b0;
        end else begin
            ctr_wrap_q <= handshake && (block_ctr_q == '1);
            if (handshake) begin
                block_ctr_q <= block_ctr_q + 32'd1;
            end
        end
    end

    assign block_ctr_o = block_ctr_q;
    assign ctr_wrap_o  = ctr_wrap_q;
`endif

endmodule

// File: tb/tb_chacha_round_ctrl.sv
// Directed, table-driven bench for chacha_round_ctrl (N = 10 double rounds).
module tb_chacha_round_ctrl;

    localparam int N  = 10;
    localparam int RW = $clog2(2 * N);

    localparam int K_IDLE  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_ROUND = 2;
    localparam int K_ADD   = 3;
    localparam int K_VALID = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start_i;
    logic          abort_i;
    logic          out_ready_i;
    logic          ready_o;
    logic          load_o;
    logic          qr_en_o;
    logic          diag_sel_o;
    logic [RW-1:0] round_idx_o;
    logic          add_o;
    logic          out_valid_o;
`ifdef CHACHA_ROUND_CTRL_BLOCK_CTR_EN
    logic [31:0]   block_ctr_o;
    logic          ctr_wrap_o;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    chacha_round_ctrl #(
        .NUM_DOUBLE_ROUNDS (N)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .out_ready_i (out_ready_i),
        .ready_o     (ready_o),
        .load_o      (load_o),
        .qr_en_o     (qr_en_o),
        .diag_sel_o  (diag_sel_o),
        .round_idx_o (round_idx_o),
        .add_o       (add_o),
        .out_valid_o (out_valid_o)
`ifdef CHACHA_ROUND_CTRL_BLOCK_CTR_EN
        ,
        .block_ctr_o (block_ctr_o),
        .ctr_wrap_o  (ctr_wrap_o)
`endif
    );

    typedef struct {
        logic          start;
        logic          abort;
        logic          ordy;
        logic          e_ready;
        logic          e_load;
        logic          e_qr;
        logic          e_diag;
        logic [RW-1:0] e_idx;
        logic          e_add;
        logic          e_valid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic a, input logic r,
                                input int kind, input int idx);
        vec_t v;
        v.start   = s;
        v.abort   = a;
        v.ordy    = r;
        v.e_ready = (kind == K_IDLE);
        v.e_load  = (kind == K_LOAD);
        v.e_qr    = (kind == K_ROUND);
        v.e_diag  = (kind == K_ROUND) ? ((idx % 2) == 1) : 1'b0;
        v.e_idx   = (kind == K_ROUND) ? RW'(idx) : '0;
        v.e_add   = (kind == K_ADD);
        v.e_valid = (kind == K_VALID);
        return v;
    endfunction

    function automatic logic [63:0] pack_out();
        return 64'({ready_o, load_o, qr_en_o, diag_sel_o, round_idx_o, add_o, out_valid_o});
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t v);
        return 64'({v.e_ready, v.e_load, v.e_qr, v.e_diag, v.e_idx, v.e_add, v.e_valid});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) for out_valid_o; expiry is counted as a miscompare.
    task automatic wait_valid(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!out_valid_o && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        check(name, 64'(out_valid_o), 64'd1);
    endtask

    task automatic start_block();
        start_i = 1'b1;
        @(negedge clock);
        start_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Phase A: idle after reset, five cycles.
        for (int c = 0; c < 5; c++) tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_IDLE, 0));

        // Phase B: single start pulse, no backpressure.
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, K_IDLE, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_LOAD, 0));
        for (int c = 0; c < 2 * N; c++) tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_ROUND, c));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_ADD, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_VALID, 0));

        // Phase C: start held high, 7 cycles of backpressure in OUT.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, K_IDLE, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, K_LOAD, 0));
        for (int c = 0; c < 2 * N; c++) tbl.push_back(mk(1'b1, 1'b0, 1'b0, K_ROUND, c));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, K_ADD, 0));
        for (int c = 0; c < 7; c++) tbl.push_back(mk(1'b1, 1'b0, 1'b0, K_VALID, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, K_VALID, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, K_IDLE, 0));

        // Phase D: held start is accepted in IDLE; abort at round index 7.
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_LOAD, 0));
        for (int c = 0; c < 7; c++) tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_ROUND, c));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, K_ROUND, 7));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_IDLE, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_IDLE, 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, K_IDLE, 0));

        reset       = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        foreach (tbl[j]) begin
            check($sformatf("vec[%0d]", j), pack_out(), pack_exp(tbl[j]));
            start_i     = tbl[j].start;
            abort_i     = tbl[j].abort;
            out_ready_i = tbl[j].ordy;
            @(negedge clock);
        end
        abort_i = 1'b0;

`ifdef CHACHA_ROUND_CTRL_BLOCK_CTR_EN
        check("ctr_after_abort", 64'(block_ctr_o), 64'd2);
`endif

        // Abort in OUT while out_ready_i is high: no handshake counted.
        out_ready_i = 1'b0;
        start_block();
        wait_valid("abort_out_reach", 40);
        abort_i     = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clock);
        abort_i = 1'b0;
        check("abort_out_state", 64'({ready_o, out_valid_o}), 64'b10);
`ifdef CHACHA_ROUND_CTRL_BLOCK_CTR_EN
        check("abort_out_ctr", 64'(block_ctr_o), 64'd2);
        check("abort_out_wrap", 64'(ctr_wrap_o), 64'd0);
`endif

        // Reset in OUT while out_ready_i is high.
        out_ready_i = 1'b0;
        start_block();
        wait_valid("reset_out_reach", 40);
        reset       = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clock);
        check("reset_out_state", 64'({ready_o, out_valid_o, add_o}), 64'b100);
`ifdef CHACHA_ROUND_CTRL_BLOCK_CTR_EN
        check("reset_out_ctr", 64'(block_ctr_o), 64'd0);
`endif
        reset = 1'b0;
        @(negedge clock);

`ifdef CHACHA_ROUND_CTRL_BLOCK_CTR_EN
        // Counter wrap from all-ones.
        force dut.block_ctr_q = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut.block_ctr_q;
        check("wrap_preload", 64'(block_ctr_o), 64'hFFFF_FFFF);
        out_ready_i = 1'b0;
        start_block();
        wait_valid("wrap_reach", 40);
        check("wrap_before", 64'(ctr_wrap_o), 64'd0);
        out_ready_i = 1'b1;
        @(negedge clock);
        check("wrap_ctr", 64'(block_ctr_o), 64'd0);
        check("wrap_pulse", 64'(ctr_wrap_o), 64'd1);
        @(negedge clock);
        check("wrap_pulse_end", 64'(ctr_wrap_o), 64'd0);
        check("wrap_ctr_hold", 64'(block_ctr_o), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
